piso: RTL and testbench

//  Parallel-in/serial-out shift register with a load handshake and a shift strobe.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_bit_counter.sv | 33 +++
 rtl/piso.sv | 114 +++++++++++
 tb/tb_piso.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso serializer.
// Holds the FSM state encoding and the bit-counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } piso_state_t;

  function automatic int piso_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: clearable up-counter of data bits shifted out.
// Ports: i_clk, i_rst (sync, active-high), i_clr, i_inc, o_last (count==N-1).
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int N = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  localparam int W = piso_cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_inc) begin
      count <= count + ONE;
    end
  end

  assign o_last = (count == LAST);

endmodule

// File: rtl/piso.sv
// piso: parallel-in/serial-out shifter, LSB first, one bit per i_shift.
// Ports: i_clk, i_rst (sync, active-high), i_data[N-1:0], i_load,
//   o_ready, i_shift, o_data, o_busy, o_done.
// Define PISO_FRAME_EN to wrap each word in START(~R)/STOP(R) bits.
module piso
  import piso_pkg::*;
#(
  parameter int   N = 8,
  parameter logic R = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_data,
  input  logic         i_load,
  output logic         o_ready,
  input  logic         i_shift,
  output logic         o_data,
  output logic         o_busy,
  output logic         o_done
);

  generate
    if (N < 1) begin : g_bad_n
      $error("piso: N must be >= 1");
    end
  endgenerate

  piso_state_t  state;
  logic [N-1:0] sreg;
  logic [N-1:0] shr;
  logic         last;
  logic         load_ok;
  logic         bit_inc;

  // Shift toward LSB, idle level enters at the top.
  always_comb begin
    shr = sreg >> 1;
    shr[N-1] = R;
  end

  assign load_ok = (state == IDLE) && i_load;
  assign bit_inc = (state == DATA) && i_shift;

  piso_bit_counter #(
    .N(N)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (load_ok),
    .i_inc (bit_inc),
    .o_last(last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      sreg   <= {N{R}};
      o_data <= R;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_load) begin
            sreg <= i_data;
`ifdef PISO_FRAME_EN
            state  <= START;
            o_data <= ~R;
`else
            state  <= DATA;
            o_data <= i_data[0];
`endif
          end
        end
`ifdef PISO_FRAME_EN
        START: begin
          if (i_shift) begin
            state  <= DATA;
            o_data <= sreg[0];
          end
        end
        STOP: begin
          if (i_shift) begin
            state  <= IDLE;
            o_data <= R;
            o_done <= 1'b1;
          end
        end
`endif
        DATA: begin
          if (i_shift) begin
            sreg <= shr;
            if (last) begin
              o_data <= R;
`ifdef PISO_FRAME_EN
              state  <= STOP;
`else
              state  <= IDLE;
              o_done <= 1'b1;
`endif
            end else begin
              o_data <= shr[0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_ready = (state == IDLE);

endmodule

// File: tb/tb_piso.sv
// tb_piso: checks piso (N=8,R=1 and N=1,R=0) against a bit-queue model.
// The model holds the bits still to be sent; each i_shift pops one.
module tb_piso;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       load;
  logic       shift;

  logic a_ready, a_data, a_busy, a_done;
  logic b_ready, b_data, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  logic qa[$];
  logic qb[$];
  logic ea_done = 1'b0;
  logic eb_done = 1'b0;

  always #5 clk = ~clk;

  piso #(.N(8), .R(1'b1)) u_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_load (load),
    .o_ready(a_ready),
    .i_shift(shift),
    .o_data (a_data),
    .o_busy (a_busy),
    .o_done (a_done)
  );

  piso #(.N(1), .R(1'b0)) u_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data[0:0]),
    .i_load (load),
    .o_ready(b_ready),
    .i_shift(shift),
    .o_data (b_data),
    .o_busy (b_busy),
    .o_done (b_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Model: frame bits, idle level when empty, done after last pop.
  task automatic model_update();
    if (rst) begin
      qa.delete();
      qb.delete();
      ea_done = 1'b0;
      eb_done = 1'b0;
    end else begin
      ea_done = 1'b0;
      eb_done = 1'b0;
      if (qa.size() == 0) begin
        if (load) begin
`ifdef PISO_FRAME_EN
          qa.push_back(1'b0);
`endif
          for (int i = 0; i < 8; i++) qa.push_back(data[i]);
`ifdef PISO_FRAME_EN
          qa.push_back(1'b1);
`endif
        end
      end else if (shift) begin
        void'(qa.pop_front());
        if (qa.size() == 0) ea_done = 1'b1;
      end
      if (qb.size() == 0) begin
        if (load) begin
`ifdef PISO_FRAME_EN
          qb.push_back(1'b1);
`endif
          qb.push_back(data[0]);
`ifdef PISO_FRAME_EN
          qb.push_back(1'b0);
`endif
        end
      end else if (shift) begin
        void'(qb.pop_front());
        if (qb.size() == 0) eb_done = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic ba;
    logic bb;
    ba = (qa.size() != 0);
    bb = (qb.size() != 0);
    chk("a_data", a_data, ba ? qa[0] : 1'b1);
    chk("a_busy", a_busy, ba);
    chk("a_ready", a_ready, !ba);
    chk("a_done", a_done, ea_done);
    chk("b_data", b_data, bb ? qb[0] : 1'b0);
    chk("b_busy", b_busy, bb);
    chk("b_ready", b_ready, !bb);
    chk("b_done", b_done, eb_done);
  endtask

  task automatic step(input logic r, input logic l,
                      input logic [7:0] d, input logic s);
    @(negedge clk);
    rst   = r;
    load  = l;
    data  = d;
    shift = s;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    data  = 8'h00;
    shift = 1'b0;

    // Reset state
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // 0xA5, full word, then idle
    step(0, 1, 8'hA5, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // 0x3C, 3 shifts, long hold
    step(0, 1, 8'h3C, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);
    // Mid-word load of 0xFF is ignored
    step(0, 1, 8'hFF, 0);
    step(0, 1, 8'hFF, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);

    // Reset after 4 shifts, then clean 0x01
    step(0, 1, 8'h96, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1);

    // Load and shift together in IDLE; shift ignored
    step(0, 1, 8'h6B, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);

    // Back-to-back: load during done cycle
    step(0, 1, 8'hC3, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 8'h5A, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           8'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
